// File: rtl/x68_line_buffer.sv
// ----------------------------------------------------------------------------
// x68_line_buffer
// Ping-pong line buffer between the sprite/text/graphics compositor and
// mister_sync. While mister_sync reads the front bank (selected by lramsel),
// the compositor streams the next line of pixels into the back bank.
//
// A written-length register per bank gates the read data. Words past the end
// of what was written this line read as 0, so no clear pass is needed.
//
// Ports
//   gclk      in   system clock
//   rstn      in   asynchronous active-low reset
//   hcomp     in   line-start pulse (1 gclk)
//   vpstart   in   frame-start pulse, only coincident with hcomp
//   lramsel   in   front (read) bank select
//   lramadr   in   read address
//   lramdat   out  registered read data (1 gclk latency)
//   req       out  fill request pulse (1 gclk, during START)
//   req_line  out  line number to render, held between requests
//   wr_valid  in   pixel valid from compositor
//   wr_ready  out  pixel accepted when wr_valid & wr_ready
//   wr_data   in   pixel data
//   wr_last   in   last pixel of the line
//   busy      out  high while filling a line
//   ovf_cnt   out  saturating count of lines not finished by the next hcomp
// ----------------------------------------------------------------------------
module x68_line_buffer #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          gclk,
    input  logic          rstn,
    input  logic          hcomp,
    input  logic          vpstart,
    input  logic          lramsel,
    input  logic [AW-1:0] lramadr,
    output logic [DW-1:0] lramdat,
    output logic          req,
    output logic [AW-1:0] req_line,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_last,
    output logic          busy,
    output logic [7:0]    ovf_cnt
);

    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_wbank;
    logic [AW-1:0]   r_wptr;
    logic [AW:0]     r_len [2];
    logic [AW-1:0]   r_fill_line;
    logic [AW-1:0]   r_req_line;
    logic [7:0]      r_ovf;
    logic [DW-1:0]   r_lramdat;

    // Both banks in one array, addressed as {bank, word}. Not reset: the
    // length registers hide stale contents.
    logic [DW-1:0]   r_mem [2*DEPTH];

    logic            w_accept;
    logic            w_wptr_max;
    logic            w_hcomp_take;
    logic [AW-1:0]   w_next_line;

    assign w_accept     = (r_state == FILL) && wr_valid;
    assign w_wptr_max   = &r_wptr;
    // hcomp landing in START is a protocol violation and is dropped entirely.
    assign w_hcomp_take = hcomp && (r_state != START);
    assign w_next_line  = vpstart ? AW'(1) : r_fill_line + 1'b1;

    // ------------------------------------------------------------------
    // Line FSM
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (hcomp) w_next = START;
            end
            START: begin
                w_next = FILL;
            end
            FILL: begin
                // A late line is abandoned at hcomp; an accept in the same
                // cycle still lands in the old bank.
                if (hcomp) begin
                    w_next = START;
                end else if (w_accept && (wr_last || w_wptr_max)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (hcomp) w_next = START;
            end
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write pointer, bank and length tracking
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            r_wbank  <= 1'b0;
            r_wptr   <= '0;
            r_len[0] <= '0;
            r_len[1] <= '0;
        end else if (r_state == START) begin
            // lramsel has already toggled for the new line, so the back bank
            // is its complement; writes can never hit the front bank.
            r_wbank         <= ~lramsel;
            r_wptr          <= '0;
            r_len[~lramsel] <= '0;
        end else if (w_accept) begin
            r_wptr          <= r_wptr + 1'b1;
            r_len[r_wbank]  <= {1'b0, r_wptr} + 1'b1;
        end
    end

    always_ff @(posedge gclk) begin
        if (w_accept) begin
            r_mem[{r_wbank, r_wptr}] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Line number and overrun counter
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            r_fill_line <= '0;
            r_req_line  <= '0;
            r_ovf       <= '0;
        end else begin
            if (w_hcomp_take) begin
                r_fill_line <= w_next_line;
                r_req_line  <= w_next_line;
            end
            if (hcomp && (r_state == FILL) && (r_ovf != 8'hFF)) begin
                r_ovf <= r_ovf + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: words at or beyond the written length read as 0
    // ------------------------------------------------------------------
    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            r_lramdat <= '0;
        end else if ({1'b0, lramadr} < r_len[lramsel]) begin
            r_lramdat <= r_mem[{lramsel, lramadr}];
        end else begin
            r_lramdat <= '0;
        end
    end

    assign lramdat  = r_lramdat;
    assign req      = (r_state == START);
    assign req_line = r_req_line;
    assign wr_ready = (r_state == FILL);
    assign busy     = (r_state == FILL);
    assign ovf_cnt  = r_ovf;

endmodule

// File: tb/tb_x68_line_buffer.sv
module tb_x68_line_buffer;

    localparam int DW = 16;
    localparam int AW = 10;

    logic          gclk = 1'b0;
    logic          rstn;
    logic          hcomp;
    logic          vpstart;
    logic          lramsel;
    logic [AW-1:0] lramadr;
    logic [DW-1:0] lramdat;
    logic          req;
    logic [AW-1:0] req_line;
    logic          wr_valid;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          wr_last;
    logic          busy;
    logic [7:0]    ovf_cnt;

    x68_line_buffer #(.DW(DW), .AW(AW)) dut (
        .gclk     (gclk),
        .rstn     (rstn),
        .hcomp    (hcomp),
        .vpstart  (vpstart),
        .lramsel  (lramsel),
        .lramadr  (lramadr),
        .lramdat  (lramdat),
        .req      (req),
        .req_line (req_line),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .busy     (busy),
        .ovf_cnt  (ovf_cnt)
    );

    always #5 gclk = ~gclk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_q [$];
    string         tag_q [$];
    logic [AW-1:0] m_line = '0;
    logic [DW-1:0] model [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a read address; the expectation is queued and compared one
    // cycle later when lramdat reflects it.
    task automatic rd(input string tag, input logic sel, input logic [AW-1:0] adr,
                      input logic [DW-1:0] e);
        lramsel = sel;
        lramadr = adr;
        exp_q.push_back({16'h0, e});
        tag_q.push_back(tag);
        tick();
        check(tag_q.pop_front(), {16'h0, lramdat}, exp_q.pop_front());
    endtask

    // Line start: hcomp with the new front bank; checks the request pulse.
    task automatic hc(input logic vp, input logic sel);
        hcomp   = 1'b1;
        vpstart = vp;
        lramsel = sel;
        m_line  = vp ? AW'(1) : m_line + 1'b1;
        tick();
        hcomp   = 1'b0;
        vpstart = 1'b0;
        check("req_high", {31'h0, req}, 32'd1);
        check("req_line", {22'h0, req_line}, {22'h0, m_line});
        tick();
        check("req_pulse_end", {31'h0, req}, 32'd0);
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic l);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    initial begin
        int acc;
        logic v;
        logic [DW-1:0] d;

        rstn = 1'b0; hcomp = 1'b0; vpstart = 1'b0; lramsel = 1'b0;
        lramadr = '0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        tick(); tick();
        check("rst_lramdat", {16'h0, lramdat}, 32'd0);
        check("rst_req", {31'h0, req}, 32'd0);
        check("rst_req_line", {22'h0, req_line}, 32'd0);
        check("rst_wr_ready", {31'h0, wr_ready}, 32'd0);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_ovf", {24'h0, ovf_cnt}, 32'd0);
        rstn = 1'b1;
        tick();

        // Empty banks read 0
        rd("t1_b0", 1'b0, 10'd5, 16'h0);
        rd("t1_b1", 1'b1, 10'd1023, 16'h0);

        // Short line with wr_last
        hc(1'b0, 1'b1);
        check("t2_ready", {31'h0, wr_ready}, 32'd1);
        wr(16'h1111, 1'b0);
        wr(16'h2222, 1'b0);
        wr(16'h3333, 1'b0);
        wr(16'h4444, 1'b1);
        check("t2_done_ready", {31'h0, wr_ready}, 32'd0);
        hc(1'b0, 1'b0);
        rd("t2_a0", 1'b0, 10'd0, 16'h1111);
        rd("t2_a1", 1'b0, 10'd1, 16'h2222);
        rd("t2_a2", 1'b0, 10'd2, 16'h3333);
        rd("t2_a3", 1'b0, 10'd3, 16'h4444);
        rd("t2_a4", 1'b0, 10'd4, 16'h0);
        rd("t2_a1023", 1'b0, 10'd1023, 16'h0);
        wr(16'h5555, 1'b1);
        check("t2_ovf", {24'h0, ovf_cnt}, 32'd0);

        // Full 1024-word line without wr_last
        hc(1'b0, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            wr_valid = 1'b1;
            wr_data  = 16'hC000 ^ 16'(i);
            tick();
        end
        check("t3_ready_drop", {31'h0, wr_ready}, 32'd0);
        check("t3_busy_drop", {31'h0, busy}, 32'd0);
        wr_data = 16'hDEAD;
        tick();
        wr_valid = 1'b0;
        hc(1'b0, 1'b0);
        rd("t3_a1023", 1'b0, 10'd1023, 16'hC3FF);
        rd("t3_a0", 1'b0, 10'd0, 16'hC000);
        rd("t3_a512", 1'b0, 10'd512, 16'hC200);
        wr(16'h0001, 1'b1);
        check("t3_ovf", {24'h0, ovf_cnt}, 32'd0);

        // Overrun: 10 words then hcomp
        hc(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) wr(16'h0A00 + 16'(k), 1'b0);
        check("t4_ovf0", {24'h0, ovf_cnt}, 32'd0);
        hc(1'b0, 1'b0);
        check("t4_ovf1", {24'h0, ovf_cnt}, 32'd1);
        rd("t4_a0", 1'b0, 10'd0, 16'h0A00);
        rd("t4_a9", 1'b0, 10'd9, 16'h0A09);
        rd("t4_a10", 1'b0, 10'd10, 16'h0);
        for (int k = 0; k < 299; k++) hc(1'b0, k[0]);
        check("t4_ovf_sat", {24'h0, ovf_cnt}, 32'd255);

        // Line numbering
        hc(1'b1, 1'b1);
        check("t5_line1", {22'h0, req_line}, 32'd1);
        hc(1'b0, 1'b0);
        hc(1'b0, 1'b1);
        hc(1'b0, 1'b0);
        check("t5_line4", {22'h0, req_line}, 32'd4);
        while (m_line != 10'd1023) hc(1'b0, m_line[0]);
        check("t5_line1023", {22'h0, req_line}, 32'd1023);
        hc(1'b0, 1'b1);
        check("t5_wrap", {22'h0, req_line}, 32'd0);

        // Random wr_valid, then reset mid-fill
        hc(1'b0, 1'b1);
        acc = 0;
        for (int c = 0; c < 200 && acc < 5; c++) begin
            v = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            wr_valid = v;
            wr_data  = d;
            tick();
            if (v) begin
                model[acc] = d;
                acc++;
            end
        end
        wr_valid = 1'b0;
        check("t6_accepts", acc, 32'd5);
        hc(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) rd("t6_seq", 1'b0, AW'(k), model[k]);
        rd("t6_tail", 1'b0, 10'd5, 16'h0);
        wr(16'h7001, 1'b0);
        wr(16'h7002, 1'b0);
        wr(16'h7003, 1'b0);
        #3;
        rstn = 1'b0;
        #1;
        check("t6_rst_ready", {31'h0, wr_ready}, 32'd0);
        check("t6_rst_busy", {31'h0, busy}, 32'd0);
        check("t6_rst_ovf", {24'h0, ovf_cnt}, 32'd0);
        check("t6_rst_line", {22'h0, req_line}, 32'd0);
        check("t6_rst_dat", {16'h0, lramdat}, 32'd0);
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 5; k++) rd("t6_rst_b0", 1'b0, AW'(k), 16'h0);
        for (int k = 0; k < 3; k++) rd("t6_rst_b1", 1'b1, AW'(k), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
